alu_arbiter: RTL and testbench

Shares one combinational `alu` instance between two execute-side requesters: the main pipeline on port 0 and a secondary address/auxiliary unit on port 1. Each requester uses a valid/ready handshake. The block arbitrates round-robin, registers the winning operand set into an issue slot that drives the ALU, and captures the ALU outputs into a result register tagged with the requester id. It sits between decode/issue and the `alu`, with writeback or consumer logic downstream.

---
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu between two requesters, with an issue slot
// and a tagged result register. Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0).
module alu_arbiter #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [2*AWIDTH-1:0] req_pc_i,
  input  logic [2*DWIDTH-1:0] req_rs1_i,
  input  logic [2*DWIDTH-1:0] req_rs2_i,
  input  logic [2*DWIDTH-1:0] req_imm_i,
  input  logic [13:0]         req_opcode_i,
  input  logic [7:0]          req_alusel_i,
  input  logic [5:0]          req_funct3_i,
  input  logic [13:0]         req_funct7_i,
  input  logic                flush_i,
  output logic [AWIDTH-1:0]   alu_pc_o,
  output logic [DWIDTH-1:0]   alu_rs1_o,
  output logic [DWIDTH-1:0]   alu_rs2_o,
  output logic [DWIDTH-1:0]   alu_imm_o,
  output logic [6:0]          alu_opcode_o,
  output logic [3:0]          alu_alusel_o,
  output logic [2:0]          alu_funct3_o,
  output logic [6:0]          alu_funct7_o,
  input  logic [DWIDTH-1:0]   alu_res_i,
  input  logic                alu_brtaken_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [DWIDTH-1:0]   res_o,
  output logic                res_brtaken_o,
  output logic                res_id_o
);

  logic              iss_valid, iss_id;
  logic [AWIDTH-1:0] iss_pc;
  logic [DWIDTH-1:0] iss_rs1, iss_rs2, iss_imm;
  logic [6:0]        iss_opcode, iss_funct7;
  logic [3:0]        iss_alusel;
  logic [2:0]        iss_funct3;
  logic              res_valid, res_id, res_brtaken;
  logic [DWIDTH-1:0] res;

  logic              iss_kill, res_kill, iss_live, res_live;
  logic              adv_res, can_issue, hs, hs_id;
  logic [1:0]        req_vld, gnt;
  logic [AWIDTH-1:0] sel_pc;
  logic [DWIDTH-1:0] sel_rs1, sel_rs2, sel_imm;
  logic [6:0]        sel_opcode, sel_funct7;
  logic [3:0]        sel_alusel;
  logic [2:0]        sel_funct3;

  // Flush kills only requester-0 entries; a killed entry behaves as an empty stage this cycle.
  assign iss_kill  = flush_i & iss_valid & ~iss_id;
  assign res_kill  = flush_i & res_valid & ~res_id;
  assign iss_live  = iss_valid & ~iss_kill;
  assign res_live  = res_valid & ~res_kill;
  assign adv_res   = iss_live & (~res_live | res_ready_i);
  assign can_issue = ~iss_live | adv_res;
  assign req_vld   = {req_valid_i[1], req_valid_i[0] & ~flush_i};

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign gnt = {req_vld[1] & ~req_vld[0], req_vld[0]};
`else
  logic last;

  // last = 1 means requester 1 won most recently, so requester 0 wins the next tie.
  assign gnt = {req_vld[1] & (~req_vld[0] | ~last), req_vld[0] & (~req_vld[1] | last)};

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (hs) begin
      last <= hs_id;
    end
  end
`endif

  assign req_ready_o = gnt & {2{can_issue}};
  assign hs          = |(req_valid_i & req_ready_o);
  assign hs_id       = req_ready_o[1];

  always_comb begin
    sel_pc     = hs_id ? req_pc_i[2*AWIDTH-1:AWIDTH]  : req_pc_i[AWIDTH-1:0];
    sel_rs1    = hs_id ? req_rs1_i[2*DWIDTH-1:DWIDTH] : req_rs1_i[DWIDTH-1:0];
    sel_rs2    = hs_id ? req_rs2_i[2*DWIDTH-1:DWIDTH] : req_rs2_i[DWIDTH-1:0];
    sel_imm    = hs_id ? req_imm_i[2*DWIDTH-1:DWIDTH] : req_imm_i[DWIDTH-1:0];
    sel_opcode = hs_id ? req_opcode_i[13:7]           : req_opcode_i[6:0];
    sel_alusel = hs_id ? req_alusel_i[7:4]            : req_alusel_i[3:0];
    sel_funct3 = hs_id ? req_funct3_i[5:3]            : req_funct3_i[2:0];
    sel_funct7 = hs_id ? req_funct7_i[13:7]           : req_funct7_i[6:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iss_valid   <= 1'b0;
      iss_id      <= 1'b0;
      iss_pc      <= '0;
      iss_rs1     <= '0;
      iss_rs2     <= '0;
      iss_imm     <= '0;
      iss_opcode  <= '0;
      iss_alusel  <= '0;
      iss_funct3  <= '0;
      iss_funct7  <= '0;
      res_valid   <= 1'b0;
      res_id      <= 1'b0;
      res         <= '0;
      res_brtaken <= 1'b0;
    end else begin
      if (hs) begin
        iss_valid  <= 1'b1;
        iss_id     <= hs_id;
        iss_pc     <= sel_pc;
        iss_rs1    <= sel_rs1;
        iss_rs2    <= sel_rs2;
        iss_imm    <= sel_imm;
        iss_opcode <= sel_opcode;
        iss_alusel <= sel_alusel;
        iss_funct3 <= sel_funct3;
        iss_funct7 <= sel_funct7;
      end else if (adv_res || iss_kill) begin
        iss_valid <= 1'b0;
      end
      if (adv_res) begin
        res_valid   <= 1'b1;
        res_id      <= iss_id;
        res         <= alu_res_i;
        res_brtaken <= alu_brtaken_i;
      end else if (res_ready_i || res_kill) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign alu_pc_o      = iss_pc;
  assign alu_rs1_o     = iss_rs1;
  assign alu_rs2_o     = iss_rs2;
  assign alu_imm_o     = iss_imm;
  assign alu_opcode_o  = iss_opcode;
  assign alu_alusel_o  = iss_alusel;
  assign alu_funct3_o  = iss_funct3;
  assign alu_funct7_o  = iss_funct7;
  assign res_valid_o   = res_live;
  assign res_o         = res;
  assign res_brtaken_o = res_brtaken;
  assign res_id_o      = res_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against an in-order scoreboard
// and a round-robin grant model. Honours ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;

  typedef struct packed {
    logic [31:0] res;
    logic        br;
    logic        id;
  } exp_t;

  logic        clk, reset, flush, res_ready;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] r_pc[2], r_rs1[2], r_rs2[2], r_imm[2];
  logic [6:0]  r_opc[2], r_f7[2];
  logic [3:0]  r_sel[2];
  logic [2:0]  r_f3[2];
  logic [31:0] alu_pc, alu_rs1, alu_rs2, alu_imm, alu_res, res;
  logic [6:0]  alu_opcode, alu_funct7;
  logic [3:0]  alu_alusel;
  logic [2:0]  alu_funct3;
  logic        alu_br, res_valid, res_br, res_id;

  exp_t exp_q[$];
  logic m_last;
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sel);
    case (sel)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a ^ b;
      4'd3:    return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic ref_br(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b);
    if (opc != 7'h63) return 1'b0;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      default: return 1'b0;
    endcase
  endfunction

  // Stand-in for the shared alu.
  assign alu_res = ref_res(alu_rs1, alu_rs2, alu_alusel);
  assign alu_br  = ref_br(alu_opcode, alu_funct3, alu_rs1, alu_rs2);

  alu_arbiter #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_pc_i     ({r_pc[1], r_pc[0]}),
    .req_rs1_i    ({r_rs1[1], r_rs1[0]}),
    .req_rs2_i    ({r_rs2[1], r_rs2[0]}),
    .req_imm_i    ({r_imm[1], r_imm[0]}),
    .req_opcode_i ({r_opc[1], r_opc[0]}),
    .req_alusel_i ({r_sel[1], r_sel[0]}),
    .req_funct3_i ({r_f3[1], r_f3[0]}),
    .req_funct7_i ({r_f7[1], r_f7[0]}),
    .flush_i      (flush),
    .alu_pc_o     (alu_pc),
    .alu_rs1_o    (alu_rs1),
    .alu_rs2_o    (alu_rs2),
    .alu_imm_o    (alu_imm),
    .alu_opcode_o (alu_opcode),
    .alu_alusel_o (alu_alusel),
    .alu_funct3_o (alu_funct3),
    .alu_funct7_o (alu_funct7),
    .alu_res_i    (alu_res),
    .alu_brtaken_i(alu_br),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_o        (res),
    .res_brtaken_o(res_br),
    .res_id_o     (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  // Scoreboard: runs just after each falling edge, after the tasks have checked that cycle.
  always begin : mon
    exp_t e;
    @(negedge clk);
    #1;
    if (reset) begin
      exp_q.delete();
      m_last = 1'b1;
    end else begin
      if (res_valid && res_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: got res=%h br=%0b id=%0d, required no result", res, res_br,
                   res_id);
        end else begin
          e = exp_q.pop_front();
          if ({res, res_br, res_id} !== {e.res, e.br, e.id}) begin
            n_fail++;
            $display("FAIL sb_result: got res=%h br=%0b id=%0d, required res=%h br=%0b id=%0d",
                     res, res_br, res_id, e.res, e.br, e.id);
          end
        end
      end
      if (flush) begin
        for (int j = exp_q.size() - 1; j >= 0; j--) begin
          if (exp_q[j].id == 1'b0) exp_q.delete(j);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.res = ref_res(r_rs1[i], r_rs2[i], r_sel[i]);
          e.br  = ref_br(r_opc[i], r_f3[i], r_rs1[i], r_rs2[i]);
          e.id  = 1'(i);
          exp_q.push_back(e);
          m_last = 1'(i);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [6:0] opc, input logic [3:0] sel, input logic [2:0] f3);
    r_pc[i]  = $urandom;
    r_imm[i] = $urandom;
    r_f7[i]  = 7'($urandom);
    r_rs1[i] = a;
    r_rs2[i] = b;
    r_opc[i] = opc;
    r_sel[i] = sel;
    r_f3[i]  = f3;
  endtask

  task automatic rand_req(input int i);
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom_range(0, 1) ? a : $urandom;
    set_req(i, a, b, $urandom_range(0, 1) ? 7'h63 : 7'h33, 4'($urandom_range(0, 4)),
            3'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    flush = 1'b0;
    res_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    int k;
    req_valid = 2'b00;
    flush = 1'b0;
    res_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 8) begin
      tick();
      k++;
    end
    tick();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    flush = 1'b0;
    res_ready = 1'b1;
    rand_req(0);
    rand_req(1);
    tick();
    tick();
    @(negedge clk);
    n_cmp++;
    if ({res_valid, res, res_br, res_id} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_res: got v=%0b res=%h br=%0b id=%0d, required all 0", res_valid, res,
               res_br, res_id);
    end
    n_cmp++;
    if ({alu_pc, alu_rs1, alu_rs2, alu_imm, alu_opcode, alu_alusel, alu_funct3,
         alu_funct7} !== 149'd0) begin
      n_fail++;
      $display("FAIL reset_alu: got pc=%h rs1=%h opc=%h, required all 0", alu_pc, alu_rs1,
               alu_opcode);
    end
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 00", req_ready);
    end
    // Reset while an operation sits in the issue slot must discard it.
    tick();
    reset = 1'b0;
    set_req(0, 32'd9, 32'd4, 7'h33, 4'd0, 3'd0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b0 || alu_rs1 !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_mid: got v=%0b alu_rs1=%h, required v=0 alu_rs1=0", res_valid,
                 alu_rs1);
      end
      tick();
    end
  endtask

  task automatic test_single_add();
    res_ready = 1'b1;
    set_req(0, 32'd5, 32'd7, 7'h33, 4'd0, 3'd0);
    req_valid = 2'b01;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL add_ready: got %b, required 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_issue: got rs1=%0d rs2=%0d v=%0b, required 5 7 0", alu_rs1, alu_rs2,
               res_valid);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b1 || res !== 32'd12 || res_id !== 1'b0) begin
      n_fail++;
      $display("FAIL add_result: got v=%0b res=%0d id=%0d, required v=1 res=12 id=0", res_valid,
               res, res_id);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_clear: got v=%0b, required 0", res_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] eg[4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    eg = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    eg = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    do_reset();
    for (int k = 0; k < 6; k++) begin
      rand_req(0);
      rand_req(1);
      req_valid = (k < 4) ? 2'b11 : 2'b00;
      @(negedge clk);
      if (k < 4) begin
        n_cmp++;
        if (req_ready !== eg[k]) begin
          n_fail++;
          $display("FAIL rr_grant%0d: got %b, required %b", k, req_ready, eg[k]);
        end
      end
      if (k >= 2) begin
        n_cmp++;
        if (res_valid !== 1'b1 || res_id !== eg[k-2][1]) begin
          n_fail++;
          $display("FAIL rr_result%0d: got v=%0b id=%0d, required v=1 id=%0d", k - 2, res_valid,
                   res_id, eg[k-2][1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a, exp_b;
    do_reset();
    res_ready = 1'b0;
    set_req(0, $urandom, $urandom, 7'h33, 4'd1, 3'd0);
    exp_a = ref_res(r_rs1[0], r_rs2[0], r_sel[0]);
    req_valid = 2'b01;
    tick();
    set_req(1, $urandom, $urandom, 7'h33, 4'd2, 3'd0);
    exp_b = ref_res(r_rs1[1], r_rs2[1], r_sel[1]);
    req_valid = 2'b10;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_second_ready: got %b, required 10", req_ready);
    end
    tick();
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 2'b00 || res_valid !== 1'b1 || res !== exp_a) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got rdy=%b v=%0b res=%h, required rdy=00 v=1 res=%h", k,
                 req_ready, res_valid, res, exp_a);
      end
      tick();
    end
    req_valid = 2'b00;
    res_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b1 || res_id !== 1'b0 || res !== exp_a) begin
      n_fail++;
      $display("FAIL bp_release_a: got v=%0b id=%0d res=%h, required v=1 id=0 res=%h", res_valid,
               res_id, res, exp_a);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b1 || res_id !== 1'b1 || res !== exp_b) begin
      n_fail++;
      $display("FAIL bp_release_b: got v=%0b id=%0d res=%h, required v=1 id=1 res=%h", res_valid,
               res_id, res, exp_b);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [31:0] exp_c;
    do_reset();
    res_ready = 1'b0;
    rand_req(1);
    exp_c = ref_res(r_rs1[1], r_rs2[1], r_sel[1]);
    req_valid = 2'b10;
    tick();
    rand_req(0);
    req_valid = 2'b01;
    tick();
    rand_req(0);
    req_valid = 2'b01;
    flush = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b1 || res_id !== 1'b1 || res !== exp_c || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_keep1: got v=%0b id=%0d res=%h rdy=%b, required v=1 id=1 res=%h rdy=00",
               res_valid, res_id, res, req_ready, exp_c);
    end
    tick();
    flush = 1'b0;
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_kill0_%0d: got v=%0b id=%0d, required v=0", k, res_valid, res_id);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_req(1, 32'd3, 32'd3, 7'h63, 4'd1, 3'd0);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b1 || res_br !== 1'b1 || res_id !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_beq: got v=%0b br=%0b id=%0d, required v=1 br=1 id=1", res_valid,
               res_br, res_id);
    end
    tick();
  endtask

  task automatic test_random();
    logic [1:0] v, eg;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rand_req(0);
      rand_req(1);
      req_valid = 2'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      v = {req_valid[1], req_valid[0] & ~flush};
`ifdef ALU_ARB_FIXED_PRIO_EN
      eg = (v == 2'b11) ? 2'b01 : v;
`else
      eg = (v == 2'b11) ? (m_last ? 2'b01 : 2'b10) : v;
`endif
      n_cmp++;
      if (req_ready !== 2'b00 && req_ready !== eg) begin
        n_fail++;
        $display("FAIL rand_grant%0d: got %b, required 00 or %b", k, req_ready, eg);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    drain();
    test_round_robin();
    drain();
    test_backpressure();
    drain();
    test_flush();
    drain();
    test_branch();
    drain();
    test_random();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
